sd_emmc_xfer_ctrl: RTL

AXI-clock-domain transfer sequencer for the SD/eMMC data FIFO pair. Moves a programmed number of fixed-size blocks between the host word streams and the 128-deep dual-clock FIFOs: host-to-card words go into the TX FIFO, card-to-host words come out of the RX FIFO. It counts words and blocks, flags block boundaries to the SD engine, and reports completion, abort and timeout.

---
 rtl/sd_emmc_pkg.sv | 17 +
 rtl/sd_emmc_xfer_wdog.sv | 31 +++
 rtl/sd_emmc_xfer_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sd_emmc_pkg.sv
// Shared types and constants for the SD/eMMC transfer sequencer.
package sd_emmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_BLK_END,
    ST_FIN
  } xfer_state_e;

  localparam int SD_FIFO_DEPTH    = 128;
  localparam int SD_MAX_BLK_WORDS = 128;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

endpackage

// File: rtl/sd_emmc_xfer_wdog.sv
// Stall watchdog: counts consecutive idle transfer cycles and flags expiry
// on the cycle that would be stall number TIMEOUT_CYC.
module sd_emmc_xfer_wdog
  import sd_emmc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic aclk,
  input  logic rst_n,
  input  logic run,
  input  logic moved,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] stall_q;

  assign expired = run && !moved && (stall_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!run || moved || expired) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: rtl/sd_emmc_xfer_ctrl.sv
// Block/word sequencer between the host streams and the SD data FIFO pair.
// Define SD_EMMC_XFER_TIMEOUT_EN to build the stall watchdog.
module sd_emmc_xfer_ctrl
  import sd_emmc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BLK_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              aclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic [7:0]        blk_words,
  input  logic [BLK_W-1:0]  blk_count,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              tx_push_n,
  output logic [DATA_W-1:0] tx_wdata,
  input  logic              tx_full,
  output logic              rx_pop_n,
  input  logic [DATA_W-1:0] rx_rdata,
  input  logic              rx_empty,
  output logic              busy,
  output logic              blk_done,
  output logic              done,
  output logic              aborted,
  output logic [BLK_W-1:0]  blks_left,
  output logic              err_timeout
);

  xfer_state_e      state_q, state_d;
  logic             dir_q;
  logic [7:0]       blk_words_q;
  logic [7:0]       word_cnt_q;
  logic [BLK_W-1:0] blks_left_q;
  logic [7:0]       blk_target;
  logic             wr_xfer, rd_xfer, moved, blk_last, timeout_hit;

  assign wr_xfer = (state_q == ST_XFER) && (dir_q == DIR_WR);
  assign rd_xfer = (state_q == ST_XFER) && (dir_q == DIR_RD);

  assign s_ready   = wr_xfer && !tx_full;
  assign tx_push_n = !(s_valid && s_ready);
  assign tx_wdata  = s_data;
  assign m_valid   = rd_xfer && !rx_empty;
  assign m_data    = rx_rdata;
  assign rx_pop_n  = !(m_valid && m_ready);

  // A programmed word count of zero stands for a full 128-word block.
  assign blk_target = (blk_words_q == 8'd0) ? 8'(SD_MAX_BLK_WORDS) : blk_words_q;
  assign moved      = !tx_push_n || !rx_pop_n;
  assign blk_last   = moved && ((word_cnt_q + 8'd1) == blk_target);

`ifdef SD_EMMC_XFER_TIMEOUT_EN
  logic err_timeout_q;

  sd_emmc_xfer_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .aclk    (aclk),
    .rst_n   (rst_n),
    .run     (state_q == ST_XFER),
    .moved   (moved),
    .expired (timeout_hit)
  );

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      err_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout_q <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    aborted = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (blk_count == '0) ? ST_FIN : ST_XFER;
      end
      ST_XFER: begin
        if (abort || timeout_hit) begin
          state_d = ST_IDLE;
          aborted = 1'b1;
        end else if (blk_last) begin
          state_d = ST_BLK_END;
        end
      end
      ST_BLK_END: begin
        if (abort) begin
          state_d = ST_IDLE;
          aborted = 1'b1;
        end else begin
          state_d = (blks_left_q != '0) ? ST_XFER : ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Word handshakes are counted even in an abort cycle, so this block
  // only looks at the handshake itself, not at the next state.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q       <= DIR_WR;
      blk_words_q <= 8'd0;
      word_cnt_q  <= 8'd0;
      blks_left_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      dir_q       <= dir;
      blk_words_q <= blk_words;
      word_cnt_q  <= 8'd0;
      blks_left_q <= blk_count;
    end else if (moved) begin
      if (blk_last) begin
        word_cnt_q  <= 8'd0;
        blks_left_q <= blks_left_q - 1'b1;
      end else begin
        word_cnt_q <= word_cnt_q + 8'd1;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign blk_done  = (state_q == ST_BLK_END);
  assign done      = (state_q == ST_FIN);
  assign blks_left = blks_left_q;

endmodule
